// File: rtl/dmem_if.sv
// Data-memory port bundle: request and response valid/ready channels.
// The master modport is the requester side, slave is the responder side.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_length;
    logic        req_sign;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output req_length, req_sign, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  req_length, req_sign, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one request in flight,
// little-endian byte/half/word access with sign/zero-extended loads.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    len_q;
    logic          sign_q;

    logic          commit;
    logic          err;
    logic [AW-1:0] idx;
    logic [4:0]    sh;
    logic [3:0]    be;
    logic [31:0]   wshift;
    logic [31:0]   rshift;
    logic [31:0]   load;

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid)  state_nx = ACCESS;
            ACCESS:  if (cnt == '0)      state_nx = RESP;
            RESP:    if (bus.rsp_ready)  state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
    end

    assign commit = (state == ACCESS) && (cnt == '0);
    assign idx    = addr_q[AW+1:2];
    assign sh     = {addr_q[1:0], 3'b000};

    always_comb begin
        err = ((addr_q >> (AW + 2)) != 32'd0);
        be  = 4'b0000;
        case (len_q)
            2'b00: be = 4'b0001 << addr_q[1:0];
            2'b01: begin
                be  = 4'b0011 << addr_q[1:0];
                err = err | addr_q[0];
            end
            2'b10: begin
                be  = 4'b1111;
                err = err | (addr_q[1:0] != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        wshift = wdata_q << sh;
        rshift = mem[idx] >> sh;
        load   = rshift;
        case (len_q)
            2'b00: load = {{24{sign_q & rshift[7]}}, rshift[7:0]};
            2'b01: load = {{16{sign_q & rshift[15]}}, rshift[15:0]};
            default: load = rshift;
        endcase
    end

    // Storage has no reset; a store dropped by reset never reaches commit.
    always_ff @(posedge clk) begin
        if (commit && write_q && !err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wshift[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            len_q         <= 2'b00;
            sign_q        <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    cnt     <= WAIT_INIT;
                    write_q <= bus.req_write;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    len_q   <= bus.req_length;
                    sign_q  <= bus.req_sign;
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= err;
                        bus.rsp_rdata <= (err || write_q) ? 32'd0 : load;
                    end
                end
                RESP: if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: WAIT_CYCLES=2 instance for data paths and errors,
// WAIT_CYCLES=0 instance for latency and throughput.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    int   lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_if a_bus ();
    dmem_if b_bus ();

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_bus.slave)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req_a(input string tag, input logic w,
                         input logic [31:0] ad, input logic [31:0] wd,
                         input logic [1:0] ln, input logic sg,
                         input logic [31:0] exp_rd, input logic exp_er,
                         input int hold, output int lt);
        int n;
        int acc;
        @(negedge clk);
        a_bus.req_valid  = 1'b1;
        a_bus.req_write  = w;
        a_bus.req_addr   = ad;
        a_bus.req_wdata  = wd;
        a_bus.req_length = ln;
        a_bus.req_sign   = sg;
        n = 0;
        while (!a_bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_bus.req_ready) check({tag, "_acc_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        a_bus.req_valid = 1'b0;
        a_bus.req_addr  = 32'hFFFF_FFFF;
        a_bus.req_wdata = 32'h5555_5555;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_bus.rsp_valid && n < 50);
        if (!a_bus.rsp_valid) check({tag, "_rsp_timeout"}, 0, 1);
        lt = cyc - acc;
        check({tag, "_rdata"}, a_bus.rsp_rdata, exp_rd);
        check({tag, "_err"}, {31'd0, a_bus.rsp_err}, {31'd0, exp_er});
        for (int i = 0; i < hold; i++) begin
            a_bus.req_valid  = 1'b1;
            a_bus.req_write  = 1'b1;
            a_bus.req_addr   = 32'h10;
            a_bus.req_wdata  = 32'h0BAD_F00D;
            a_bus.req_length = 2'b10;
            @(negedge clk);
            check({tag, "_bp_valid"}, {31'd0, a_bus.rsp_valid}, 1);
            check({tag, "_bp_rdata"}, a_bus.rsp_rdata, exp_rd);
            check({tag, "_bp_err"}, {31'd0, a_bus.rsp_err}, {31'd0, exp_er});
            check({tag, "_bp_ready"}, {31'd0, a_bus.req_ready}, 0);
        end
        a_bus.req_valid = 1'b0;
        a_bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        a_bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int accs[$];
        a_bus.req_valid = 0; a_bus.req_write = 0; a_bus.req_addr = 0;
        a_bus.req_wdata = 0; a_bus.req_length = 0; a_bus.req_sign = 0;
        a_bus.rsp_ready = 0;
        b_bus.req_valid = 0; b_bus.req_write = 0; b_bus.req_addr = 0;
        b_bus.req_wdata = 0; b_bus.req_length = 0; b_bus.req_sign = 0;
        b_bus.rsp_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'd0, a_bus.req_ready}, 1);
        check("rst_rsp_valid", {31'd0, a_bus.rsp_valid}, 0);
        check("rst_rdata", a_bus.rsp_rdata, 0);
        check("rst_err", {31'd0, a_bus.rsp_err}, 0);

        req_a("st10", 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0, 0, 0, lat);
        check("st10_latency", lat, 3);
        req_a("ld10", 0, 32'h10, 0, 2'b10, 0, 32'hDEADBEEF, 0, 0, lat);

        req_a("st20", 1, 32'h20, 32'h11223344, 2'b10, 0, 0, 0, 0, lat);
        req_a("sb21", 1, 32'h21, 32'hFFFF_FFAA, 2'b00, 1, 0, 0, 0, lat);
        req_a("ld20", 0, 32'h20, 0, 2'b10, 1, 32'h1122AA44, 0, 0, lat);
        req_a("lbs21", 0, 32'h21, 0, 2'b00, 1, 32'hFFFFFFAA, 0, 0, lat);
        req_a("lbu21", 0, 32'h21, 0, 2'b00, 0, 32'h000000AA, 0, 0, lat);
        req_a("lhs22", 0, 32'h22, 0, 2'b01, 1, 32'h00001122, 0, 0, lat);
        req_a("lhs20", 0, 32'h20, 0, 2'b01, 1, 32'hFFFFAA44, 0, 0, lat);
        req_a("lhu20", 0, 32'h20, 0, 2'b01, 0, 32'h0000AA44, 0, 0, lat);
        req_a("lbs23", 0, 32'h23, 0, 2'b00, 1, 32'h00000011, 0, 0, lat);

        req_a("st24", 1, 32'h24, 32'hCAFEF00D, 2'b10, 0, 0, 0, 0, lat);
        req_a("e_lh23", 0, 32'h23, 0, 2'b01, 1, 0, 1, 0, lat);
        req_a("e_sw26", 1, 32'h26, 32'h99999999, 2'b10, 0, 0, 1, 0, lat);
        req_a("e_len3", 0, 32'h24, 0, 2'b11, 0, 0, 1, 0, lat);
        req_a("e_sl3", 1, 32'h24, 32'h77777777, 2'b11, 0, 0, 1, 0, lat);
        req_a("e_oor", 0, 32'h1000, 0, 2'b10, 0, 0, 1, 0, lat);
        req_a("e_sboor", 1, 32'h1024, 32'h66, 2'b00, 0, 0, 1, 0, lat);
        req_a("ld24", 0, 32'h24, 0, 2'b10, 0, 32'hCAFEF00D, 0, 0, lat);
        req_a("ld1024", 0, 32'h24, 0, 2'b10, 0, 32'hCAFEF00D, 0, 0, lat);

        req_a("bp", 0, 32'h10, 0, 2'b10, 0, 32'hDEADBEEF, 0, 5, lat);
        req_a("bp_after", 0, 32'h10, 0, 2'b10, 0, 32'hDEADBEEF, 0, 0, lat);

        // WAIT_CYCLES=0 latency
        @(negedge clk);
        b_bus.req_valid = 1; b_bus.req_write = 1; b_bus.req_addr = 32'h8;
        b_bus.req_wdata = 32'hA5A5_0F0F; b_bus.req_length = 2'b10;
        check("b_ready", {31'd0, b_bus.req_ready}, 1);
        @(posedge clk);
        #1;
        b_bus.req_valid = 0;
        @(negedge clk);
        check("b_early_valid", {31'd0, b_bus.rsp_valid}, 0);
        @(negedge clk);
        check("b_valid_n1", {31'd0, b_bus.rsp_valid}, 1);
        check("b_st_rdata", b_bus.rsp_rdata, 0);
        b_bus.rsp_ready = 1;
        @(posedge clk);
        #1;
        b_bus.rsp_ready = 0;
        @(negedge clk);
        b_bus.req_valid = 1; b_bus.req_write = 0; b_bus.req_addr = 32'hA;
        b_bus.req_length = 2'b01; b_bus.req_sign = 1;
        @(posedge clk);
        #1;
        b_bus.req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("b_lh_valid", {31'd0, b_bus.rsp_valid}, 1);
        check("b_lh_rdata", b_bus.rsp_rdata, 32'hFFFFA5A5);
        b_bus.rsp_ready = 1;
        @(posedge clk);
        #1;

        // WAIT_CYCLES=0 throughput
        @(negedge clk);
        b_bus.req_valid = 1; b_bus.req_write = 1; b_bus.req_addr = 32'h0;
        b_bus.req_wdata = 32'h5; b_bus.req_length = 2'b10;
        for (int i = 0; i < 12; i++) begin
            if (b_bus.req_valid && b_bus.req_ready) accs.push_back(cyc + 1);
            @(negedge clk);
        end
        b_bus.req_valid = 0;
        check("b_tp_count", accs.size(), 4);
        if (accs.size() >= 3) begin
            check("b_tp_gap1", accs[1] - accs[0], 3);
            check("b_tp_gap2", accs[2] - accs[1], 3);
        end
        repeat (3) @(negedge clk);
        b_bus.rsp_ready = 0;

        // Reset while a store sits in ACCESS
        req_a("z40", 1, 32'h40, 0, 2'b10, 0, 0, 0, 0, lat);
        @(negedge clk);
        a_bus.req_valid = 1; a_bus.req_write = 1; a_bus.req_addr = 32'h40;
        a_bus.req_wdata = 32'h12345678; a_bus.req_length = 2'b10;
        @(posedge clk);
        #1;
        a_bus.req_valid = 0;
        @(negedge clk);
        check("mid_ready_low", {31'd0, a_bus.req_ready}, 0);
        rst_n = 0;
        #1;
        check("rst2_req_ready", {31'd0, a_bus.req_ready}, 1);
        check("rst2_rsp_valid", {31'd0, a_bus.rsp_valid}, 0);
        check("rst2_rdata", a_bus.rsp_rdata, 0);
        check("rst2_err", {31'd0, a_bus.rsp_err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        check("post_rst_valid", {31'd0, a_bus.rsp_valid}, 0);
        req_a("ld40", 0, 32'h40, 0, 2'b10, 0, 0, 0, 0, lat);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port. Accepts one load/store request at a time over a valid/ready handshake and holds it for a configurable number of wait states. It then performs a little-endian byte/half/word access on a word-organised storage array and returns read data over a second valid/ready handshake. Loads are sign- or zero-extended. It replaces the zero-latency data memory so the core's MEM stage can be exercised against a real wait-state responder.

## Interface
- DEPTH_WORDS, 1024: storage size in 32-bit words (power of two)
- WAIT_CYCLES, 2: wait states between request acceptance and response (0 allowed)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_length  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  load result, right-aligned and extended; 0 for stores and errors
- rsp_err  out  1  request was misaligned, reserved length, or out of range

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - ACCESS: counting wait states.
  - RESP: rsp_valid=1.
- IDLE -> ACCESS on req_valid&&req_ready. On that edge, latch write, addr, wdata, length and sign, and load the wait counter with WAIT_CYCLES.
- ACCESS: decrement the counter each cycle. When the counter is 0, perform the access and go to RESP on that edge. With WAIT_CYCLES=0, ACCESS lasts exactly one cycle.
- RESP -> IDLE on rsp_valid&&rsp_ready. rsp_rdata and rsp_err stay stable while waiting for rsp_ready.
- Word index = addr[clog2(DEPTH_WORDS)+1:2]. Byte lane = addr[1:0]. Little-endian: byte k of a word is bits [8k+7:8k].
- Error conditions:
  - length=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr >= 4*DEPTH_WORDS
- On error: no store, rsp_rdata=0, rsp_err=1. Never wrap an out-of-range address.
- Store: update only the addressed lanes (1, 2 or 4 bytes). Other bytes are unchanged. rsp_rdata=0.
- Load: select the lane(s). Extend bit 7 (byte) or bit 15 (half) when sign=1, otherwise zero-fill. sign is ignored for word loads and for stores.
- Storage array is not reset. Its contents are undefined until written.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Request accepted at edge N:
  - Store commits and read data is captured at edge N+1+WAIT_CYCLES.
  - rsp_valid is high in the cycle after that edge.
  - Earliest response handshake is edge N+2+WAIT_CYCLES.
- req_ready is low in ACCESS and RESP. Requests presented there are ignored, not queued.
- Back-to-back: the next request is accepted no earlier than the edge after the response handshake. Peak throughput is one request per WAIT_CYCLES+3 cycles.
- A load that immediately follows a store to the same word returns the stored data.
- rst_n asserted in any state: return to IDLE immediately and clear rsp_valid, rsp_rdata and rsp_err.
  - A store still in ACCESS is dropped and never committed.
  - A store already committed (state RESP) stays in memory.
- req_* inputs may change freely after acceptance. Only the latched copies are used.
- All outputs are driven from registers except req_ready, which is decoded from the state register. No combinational path from any input to any output.

## Test plan
- Word round-trip, WAIT_CYCLES=2: store 0xDEADBEEF @0x10 accepted at edge N -> rsp_valid rises after edge N+3, rdata=0, err=0. Then word load @0x10 -> rdata=0xDEADBEEF.
- Sub-word lanes: word store 0x11223344 @0x20, then byte store 0xAA @0x21 -> word load = 0x1122AA44.
  - Signed byte load @0x21 -> 0xFFFFFFAA.
  - Unsigned byte load @0x21 -> 0x000000AA.
  - Signed half load @0x22 -> 0x00001122.
- Errors: half load @0x23, word store @0x26, length=11, and word load @4*DEPTH_WORDS -> err=1, rdata=0. A following word load of the 0x24 word shows it unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err remain stable. req_valid pulsed during this time is not accepted (req_ready=0).
- WAIT_CYCLES=0 build: accept at edge N -> rsp_valid high after edge N+1. Continuous req_valid with rsp_ready=1 -> one acceptance every 3 cycles.
- Reset mid-operation: store 0x12345678 @0x40 over previous 0 contents, rst_n low while in ACCESS -> after release, outputs at reset values and a word load @0x40 returns 0.
